// File: rtl/pcie_rx_credit_pkg.sv
// Shared TLP definitions for the RX credit-return path: fmt/type codes,
// credit unit, accumulator widths, parser states and TLP classification.
package pcie_rx_credit_pkg;

    // One data credit covers four DW of payload.
    localparam int CREDIT_DW   = 4;
    // Pending-credit accumulator widths.
    localparam int HDR_ACC_W   = 8;
    localparam int DATA_ACC_W  = 12;
    // Largest amount returned with one pulse.
    localparam int HDR_MAXRET  = 1;
    localparam int DATA_MAXRET = 255;
    // Data credits per TLP reach 256 (1024 DW), so the add path needs 9 bits.
    localparam int ADD_W       = 9;

    // Word0 type codes.
    localparam logic [4:0] TYPE_MEM    = 5'b00000;
    localparam logic [4:0] TYPE_MEM_LK = 5'b00001;
    localparam logic [4:0] TYPE_IO     = 5'b00010;
    localparam logic [4:0] TYPE_CFG0   = 5'b00100;
    localparam logic [4:0] TYPE_CFG1   = 5'b00101;
    localparam logic [3:0] TYPE_CPL_HI = 4'b0101;
    localparam logic [1:0] TYPE_MSG_HI = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_W1,
        ST_BODY
    } parse_state_e;

    typedef enum logic [1:0] {
        TLP_POSTED,
        TLP_NONPOSTED,
        TLP_CPL,
        TLP_UNKNOWN
    } tlp_class_e;

    // fmt[1] flags a TLP that carries payload.
    function automatic tlp_class_e classify(input logic [1:0] fmt, input logic [4:0] typ);
        logic has_data;
        has_data = fmt[1];
        if ((typ == TYPE_MEM && has_data) || typ[4:3] == TYPE_MSG_HI)
            return TLP_POSTED;
        if (((typ == TYPE_MEM || typ == TYPE_MEM_LK) && !has_data) ||
            typ == TYPE_IO || typ == TYPE_CFG0 || typ == TYPE_CFG1)
            return TLP_NONPOSTED;
        if (typ[4:1] == TYPE_CPL_HI)
            return TLP_CPL;
        return TLP_UNKNOWN;
    endfunction

    // ceil(length/4) where a length field of 0 encodes 1024 DW.
    function automatic logic [ADD_W-1:0] data_credits(input logic [9:0] len);
        logic [10:0] dw;
        dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        return ADD_W'((dw + 11'(CREDIT_DW - 1)) / 11'(CREDIT_DW));
    endfunction

endpackage

// File: rtl/pcie_credit_acc.sv
// Pending-credit accumulator: adds newly earned credits, saturates at
// all-ones with a sticky overflow flag, and returns up to MAXRET per cycle
// unless held off.
module pcie_credit_acc #(
    parameter  int WIDTH  = 8,
    parameter  int MAXRET = 1,
    parameter  int ADD_W  = 1,
    localparam int NUM_W  = $clog2(MAXRET + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic [ADD_W-1:0] add_i,
    output logic [NUM_W-1:0] num_o,
    output logic             ovf_o
);
    localparam logic [WIDTH-1:0] RET_CAP = WIDTH'(MAXRET);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   raw_sum;
    logic [WIDTH-1:0] sat_sum;
    logic [WIDTH-1:0] ret_amt;

    function automatic logic [WIDTH-1:0] cap_ret(input logic [WIDTH-1:0] s);
        return (s > RET_CAP) ? RET_CAP : s;
    endfunction

    // Add and return in the same cycle; the returned amount leaves pend.
    always_comb begin
        raw_sum = {1'b0, pend_q} + (WIDTH+1)'(add_i);
        sat_sum = raw_sum[WIDTH] ? '1 : raw_sum[WIDTH-1:0];
        ret_amt = (!hold_i && sat_sum != '0) ? cap_ret(sat_sum) : '0;
        pend_d  = sat_sum - ret_amt;
        num_d   = NUM_W'(ret_amt);
        ovf_d   = ovf_q | raw_sum[WIDTH];
    end

    // Accumulator, return amount and sticky overflow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            num_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            num_q  <= num_d;
            ovf_q  <= ovf_d;
        end
    end

    assign num_o = num_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/pcie_rx_credit.sv
// RX credit-return block: parses TLP word0/word1 from the core, classifies
// each TLP and feeds four pending-credit accumulators that drive the core's
// processed/num credit-return inputs.
module pcie_rx_credit
    import pcie_rx_credit_pkg::*;
(
    input  logic        sys_clk_125,
    input  logic        rstn,
    input  logic [15:0] rx_data_vc0,
    input  logic        rx_st_vc0,
    input  logic        rx_end_vc0,
    input  logic        credit_hold,
    output logic        ph_processed_vc0,
    output logic        nph_processed_vc0,
    output logic        pd_processed_vc0,
    output logic        npd_processed_vc0,
    output logic [7:0]  pd_num_vc0,
    output logic [7:0]  npd_num_vc0,
    output logic        ph_buf_status_vc0,
    output logic        pd_buf_status_vc0,
    output logic        nph_buf_status_vc0,
    output logic        npd_buf_status_vc0,
    output logic [15:0] tlp_cnt,
    output logic        cpl_seen,
    output logic        unknown_seen,
    output logic        cred_ovf
);
    parse_state_e     state_q, state_d;
    logic [1:0]       fmt_q, fmt_d;
    logic [4:0]       type_q, type_d;
    logic [9:0]       len_q, len_d;
    logic             commit;
    logic [9:0]       commit_len;
    logic             commit_len_vld;
    tlp_class_e       commit_cls;
    logic [ADD_W-1:0] commit_data;
    logic             ph_add_q, ph_add_d, nph_add_q, nph_add_d;
    logic [ADD_W-1:0] pd_add_q, pd_add_d, npd_add_q, npd_add_d;
    logic             cpl_q, cpl_d, unk_q, unk_d;
    logic [15:0]      tlp_cnt_q, tlp_cnt_d;
    logic             ph_num, nph_num;
    logic [7:0]       pd_num, npd_num;
    logic             ph_ovf, nph_ovf, pd_ovf, npd_ovf;
    logic             unused_addr_msb;

    // Bit 15 belongs to neither the word0 fields nor the length field.
    assign unused_addr_msb = rx_data_vc0[15];

    // Parser: a new rx_st while a TLP is open commits it with what was captured;
    // rx_st together with rx_end describes a one-word TLP, which is dropped.
    always_comb begin
        state_d        = state_q;
        fmt_d          = fmt_q;
        type_d         = type_q;
        len_d          = len_q;
        commit         = 1'b0;
        commit_len     = len_q;
        commit_len_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_st_vc0 && !rx_end_vc0) begin
                    fmt_d   = rx_data_vc0[14:13];
                    type_d  = rx_data_vc0[12:8];
                    state_d = ST_W1;
                end
            end
            ST_W1: begin
                if (rx_st_vc0) begin
                    commit  = 1'b1;
                    fmt_d   = rx_data_vc0[14:13];
                    type_d  = rx_data_vc0[12:8];
                    state_d = rx_end_vc0 ? ST_IDLE : ST_W1;
                end else begin
                    len_d = rx_data_vc0[9:0];
                    if (rx_end_vc0) begin
                        commit         = 1'b1;
                        commit_len     = rx_data_vc0[9:0];
                        commit_len_vld = 1'b1;
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (rx_st_vc0) begin
                    commit         = 1'b1;
                    commit_len_vld = 1'b1;
                    fmt_d          = rx_data_vc0[14:13];
                    type_d         = rx_data_vc0[12:8];
                    state_d        = rx_end_vc0 ? ST_IDLE : ST_W1;
                end else if (rx_end_vc0) begin
                    commit         = 1'b1;
                    commit_len_vld = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Turn a committed TLP into header/data credit adds and event pulses.
    always_comb begin
        commit_cls  = classify(fmt_q, type_q);
        commit_data = (commit_len_vld && fmt_q[1]) ? data_credits(commit_len) : '0;
        ph_add_d    = 1'b0;
        nph_add_d   = 1'b0;
        pd_add_d    = '0;
        npd_add_d   = '0;
        cpl_d       = 1'b0;
        unk_d       = 1'b0;
        tlp_cnt_d   = tlp_cnt_q + 16'(commit);
        if (commit) begin
            case (commit_cls)
                TLP_POSTED: begin
                    ph_add_d = 1'b1;
                    pd_add_d = commit_data;
                end
                TLP_NONPOSTED: begin
                    nph_add_d = 1'b1;
                    npd_add_d = commit_data;
                end
                TLP_CPL: cpl_d = 1'b1;
                default: unk_d = 1'b1;
            endcase
        end
    end

    // Parser state, credit adds, event pulses and TLP counter.
    always_ff @(posedge sys_clk_125 or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ph_add_q  <= 1'b0;
            nph_add_q <= 1'b0;
            pd_add_q  <= '0;
            npd_add_q <= '0;
            cpl_q     <= 1'b0;
            unk_q     <= 1'b0;
            tlp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_add_q  <= ph_add_d;
            nph_add_q <= nph_add_d;
            pd_add_q  <= pd_add_d;
            npd_add_q <= npd_add_d;
            cpl_q     <= cpl_d;
            unk_q     <= unk_d;
            tlp_cnt_q <= tlp_cnt_d;
        end
    end

    // Captured header fields; only meaningful while a TLP is open.
    always_ff @(posedge sys_clk_125) begin
        fmt_q  <= fmt_d;
        type_q <= type_d;
        len_q  <= len_d;
    end

    pcie_credit_acc #(.WIDTH(HDR_ACC_W), .MAXRET(HDR_MAXRET), .ADD_W(1)) u_ph_acc (
        .clk_i(sys_clk_125), .rst_ni(rstn), .hold_i(credit_hold),
        .add_i(ph_add_q), .num_o(ph_num), .ovf_o(ph_ovf)
    );

    pcie_credit_acc #(.WIDTH(HDR_ACC_W), .MAXRET(HDR_MAXRET), .ADD_W(1)) u_nph_acc (
        .clk_i(sys_clk_125), .rst_ni(rstn), .hold_i(credit_hold),
        .add_i(nph_add_q), .num_o(nph_num), .ovf_o(nph_ovf)
    );

    pcie_credit_acc #(.WIDTH(DATA_ACC_W), .MAXRET(DATA_MAXRET), .ADD_W(ADD_W)) u_pd_acc (
        .clk_i(sys_clk_125), .rst_ni(rstn), .hold_i(credit_hold),
        .add_i(pd_add_q), .num_o(pd_num), .ovf_o(pd_ovf)
    );

    pcie_credit_acc #(.WIDTH(DATA_ACC_W), .MAXRET(DATA_MAXRET), .ADD_W(ADD_W)) u_npd_acc (
        .clk_i(sys_clk_125), .rst_ni(rstn), .hold_i(credit_hold),
        .add_i(npd_add_q), .num_o(npd_num), .ovf_o(npd_ovf)
    );

    assign ph_processed_vc0   = ph_num;
    assign nph_processed_vc0  = nph_num;
    assign pd_processed_vc0   = |pd_num;
    assign npd_processed_vc0  = |npd_num;
    assign pd_num_vc0         = pd_num;
    assign npd_num_vc0        = npd_num;
    assign ph_buf_status_vc0  = 1'b0;
    assign pd_buf_status_vc0  = 1'b0;
    assign nph_buf_status_vc0 = 1'b0;
    assign npd_buf_status_vc0 = 1'b0;
    assign tlp_cnt            = tlp_cnt_q;
    assign cpl_seen           = cpl_q;
    assign unknown_seen       = unk_q;
    assign cred_ovf           = ph_ovf | nph_ovf | pd_ovf | npd_ovf;

endmodule

// File: tb/tb_pcie_rx_credit.sv
// Testbench for pcie_rx_credit: directed vector table, hand-written corner
// sequences and a randomized run checked against a TLP-level credit model.
module tb_pcie_rx_credit;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] rx_data;
    logic        rx_st, rx_end, hold;
    logic        ph_p, nph_p, pd_p, npd_p;
    logic [7:0]  pd_num, npd_num;
    logic        ph_bs, pd_bs, nph_bs, npd_bs;
    logic [15:0] tlp_cnt;
    logic        cpl_seen, unk_seen, cred_ovf;

    always #4 clk = ~clk;

    pcie_rx_credit dut (
        .sys_clk_125(clk), .rstn(rstn), .rx_data_vc0(rx_data),
        .rx_st_vc0(rx_st), .rx_end_vc0(rx_end), .credit_hold(hold),
        .ph_processed_vc0(ph_p), .nph_processed_vc0(nph_p),
        .pd_processed_vc0(pd_p), .npd_processed_vc0(npd_p),
        .pd_num_vc0(pd_num), .npd_num_vc0(npd_num),
        .ph_buf_status_vc0(ph_bs), .pd_buf_status_vc0(pd_bs),
        .nph_buf_status_vc0(nph_bs), .npd_buf_status_vc0(npd_bs),
        .tlp_cnt(tlp_cnt), .cpl_seen(cpl_seen), .unknown_seen(unk_seen),
        .cred_ovf(cred_ovf)
    );

    typedef struct {
        logic [1:0] fmt;
        logic [4:0] typ;
        int         len;
        int         nw;
        int         ph, nph, pd, npd, cpl, unk;
    } vec_t;

    vec_t       vecs[12];
    logic [4:0] pool[12];
    int total = 0, bad = 0;
    int obs_ph = 0, obs_nph = 0, obs_pd = 0, obs_npd = 0, obs_cpl = 0, obs_unk = 0;
    int exp_tlp = 0;
    bit rand_hold = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: inputs set beforehand are sampled, outputs are read 1ns later.
    task automatic step();
        bit h;
        h = hold;
        @(posedge clk);
        #1;
        obs_ph  += int'(ph_p);
        obs_nph += int'(nph_p);
        obs_pd  += int'(pd_num);
        obs_npd += int'(npd_num);
        obs_cpl += int'(cpl_seen);
        obs_unk += int'(unk_seen);
        check("pd_num_vs_pulse", int'(pd_num != 8'd0), int'(pd_p));
        check("npd_num_vs_pulse", int'(npd_num != 8'd0), int'(npd_p));
        check("buf_status", int'({ph_bs, pd_bs, nph_bs, npd_bs}), 0);
        if (h) check("hold_blocks_return", int'({ph_p, nph_p, pd_p, npd_p}), 0);
        if (rand_hold) hold = ($urandom_range(0, 3) == 0);
    endtask

    task automatic drive_word(input bit st, input bit en, input logic [15:0] d);
        rx_st = st; rx_end = en; rx_data = d;
        step();
        rx_st = 1'b0; rx_end = 1'b0;
    endtask

    function automatic logic [15:0] w0(input logic [1:0] fmt, input logic [4:0] typ);
        return {1'($urandom), fmt, typ, 8'($urandom)};
    endfunction

    function automatic logic [15:0] w1(input int len);
        return {6'($urandom), 10'(len)};
    endfunction

    task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ, input int len, input int nw);
        for (int i = 0; i < nw; i++) begin
            rx_st  = (i == 0);
            rx_end = (i == nw - 1);
            if (i == 0)      rx_data = w0(fmt, typ);
            else if (i == 1) rx_data = w1(len);
            else             rx_data = 16'($urandom);
            step();
        end
        rx_st = 1'b0; rx_end = 1'b0; rx_data = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // TLP-level credit rules: posted/non-posted earn 1 header credit plus
    // ceil(DW/4) data credits when carrying payload; others earn nothing.
    function automatic void model(input logic [1:0] fmt, input logic [4:0] typ, input int len,
                                  output int hp, output int hn, output int dp, output int dn,
                                  output int c, output int u);
        int dw, dc, t;
        t  = int'(typ);
        dw = (len == 0) ? 1024 : len;
        dc = fmt[1] ? (dw + 3) / 4 : 0;
        hp = 0; hn = 0; dp = 0; dn = 0; c = 0; u = 0;
        if ((t == 0 && fmt[1]) || (t >= 16 && t <= 23)) begin
            hp = 1; dp = dc;
        end else if (((t == 0 || t == 1) && !fmt[1]) || t == 2 || t == 4 || t == 5) begin
            hn = 1; dn = dc;
        end else if (t == 10 || t == 11) begin
            c = 1;
        end else begin
            u = 1;
        end
    endfunction

    initial begin
        int s_ph, s_nph, s_pd, s_npd, s_cpl, s_unk, lat;
        int e_ph, e_nph, e_pd, e_npd, e_cpl, e_unk;

        vecs[0]  = '{2'b10, 5'b00000,   10, 7, 1, 0,   3, 0, 0, 0}; // MWr
        vecs[1]  = '{2'b10, 5'b00100,    1, 4, 0, 1,   0, 1, 0, 0}; // CfgWr
        vecs[2]  = '{2'b00, 5'b00000,    0, 3, 0, 1,   0, 0, 0, 0}; // MRd 1024
        vecs[3]  = '{2'b00, 5'b01010,    1, 3, 0, 0,   0, 0, 1, 0}; // Cpl
        vecs[4]  = '{2'b10, 5'b01011,    4, 4, 0, 0,   0, 0, 1, 0}; // CplDLk
        vecs[5]  = '{2'b01, 5'b10011,    0, 4, 1, 0,   0, 0, 0, 0}; // Msg
        vecs[6]  = '{2'b11, 5'b10000,    5, 6, 1, 0,   2, 0, 0, 0}; // MsgD
        vecs[7]  = '{2'b10, 5'b00010,    1, 4, 0, 1,   0, 1, 0, 0}; // IOWr
        vecs[8]  = '{2'b01, 5'b00001,    8, 2, 0, 1,   0, 0, 0, 0}; // MRdLk
        vecs[9]  = '{2'b00, 5'b00011,    4, 3, 0, 0,   0, 0, 0, 1}; // unknown
        vecs[10] = '{2'b11, 5'b00000,    4, 2, 1, 0,   1, 0, 0, 0}; // MWr 4DW hdr
        vecs[11] = '{2'b10, 5'b00000, 1023, 5, 1, 0, 256, 0, 0, 0}; // MWr 1023
        pool = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd10, 5'd11, 5'd16, 5'd19, 5'd23, 5'd3, 5'd27};

        rstn = 1'b0; rx_data = '0; rx_st = 1'b0; rx_end = 1'b0; hold = 1'b0;
        idle(2);
        check("rst_ph_nph", int'({ph_p, nph_p}), 0);
        check("rst_pd_npd", int'({pd_p, npd_p}), 0);
        check("rst_nums", int'({pd_num, npd_num}), 0);
        check("rst_tlp_cnt", int'(tlp_cnt), 0);
        check("rst_events", int'({cpl_seen, unk_seen, cred_ovf}), 0);
        rstn = 1'b1;
        idle(2);

        // Vector table, one TLP per entry with credit_hold low.
        foreach (vecs[i]) begin
            s_ph = obs_ph; s_nph = obs_nph; s_pd = obs_pd; s_npd = obs_npd;
            s_cpl = obs_cpl; s_unk = obs_unk;
            send_tlp(vecs[i].fmt, vecs[i].typ, vecs[i].len, vecs[i].nw);
            lat = 0;
            for (int k = 2; k <= 8; k++) begin
                step();
                if (lat == 0 && (ph_p || nph_p || pd_p || npd_p)) lat = k;
            end
            exp_tlp++;
            check($sformatf("vec%0d_ph", i), obs_ph - s_ph, vecs[i].ph);
            check($sformatf("vec%0d_nph", i), obs_nph - s_nph, vecs[i].nph);
            check($sformatf("vec%0d_pd", i), obs_pd - s_pd, vecs[i].pd);
            check($sformatf("vec%0d_npd", i), obs_npd - s_npd, vecs[i].npd);
            check($sformatf("vec%0d_cpl", i), obs_cpl - s_cpl, vecs[i].cpl);
            check($sformatf("vec%0d_unk", i), obs_unk - s_unk, vecs[i].unk);
            check($sformatf("vec%0d_tlp_cnt", i), int'(tlp_cnt), exp_tlp);
            if (vecs[i].ph + vecs[i].nph > 0) check($sformatf("vec%0d_latency", i), lat, 2);
        end

        // MWr of 1024 DW: 256 data credits split as 255 then 1.
        send_tlp(2'b10, 5'b00000, 0, 3);
        exp_tlp++;
        step();
        check("big_first_ph", int'(ph_p), 1);
        check("big_first_pd_num", int'(pd_num), 255);
        step();
        check("big_second_pd_num", int'(pd_num), 1);
        step();
        check("big_third_pd", int'({pd_p, pd_num}), 0);
        idle(2);

        // Five Msg TLPs under hold, then release.
        hold = 1'b1;
        s_ph = obs_ph;
        for (int i = 0; i < 5; i++) send_tlp(2'b01, 5'b10000, 1, 2);
        exp_tlp += 5;
        idle(3);
        check("hold_no_ph", obs_ph - s_ph, 0);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("release_ph%0d", i), int'(ph_p), 1);
        end
        step();
        check("release_ph_done", int'(ph_p), 0);
        check("release_tlp_cnt", int'(tlp_cnt), exp_tlp);

        // rx_st during BODY of an MWr, followed by a normal CfgWr.
        s_ph = obs_ph; s_nph = obs_nph; s_pd = obs_pd; s_npd = obs_npd;
        drive_word(1'b1, 1'b0, w0(2'b10, 5'b00000));
        drive_word(1'b0, 1'b0, w1(8));
        drive_word(1'b0, 1'b0, 16'($urandom));
        drive_word(1'b1, 1'b0, w0(2'b10, 5'b00100));
        drive_word(1'b0, 1'b0, w1(1));
        drive_word(1'b0, 1'b1, 16'($urandom));
        idle(6);
        exp_tlp += 2;
        check("body_restart_ph", obs_ph - s_ph, 1);
        check("body_restart_pd", obs_pd - s_pd, 2);
        check("body_restart_nph", obs_nph - s_nph, 1);
        check("body_restart_npd", obs_npd - s_npd, 1);
        check("body_restart_tlp_cnt", int'(tlp_cnt), exp_tlp);

        // rx_st during W1: first TLP earns only its header credit.
        s_ph = obs_ph; s_pd = obs_pd;
        drive_word(1'b1, 1'b0, w0(2'b10, 5'b00000));
        drive_word(1'b1, 1'b0, w0(2'b01, 5'b10000));
        drive_word(1'b0, 1'b1, w1(12));
        idle(6);
        exp_tlp += 2;
        check("w1_restart_ph", obs_ph - s_ph, 2);
        check("w1_restart_pd", obs_pd - s_pd, 0);
        check("w1_restart_tlp_cnt", int'(tlp_cnt), exp_tlp);

        // rx_st and rx_end together are ignored.
        s_ph = obs_ph; s_pd = obs_pd;
        drive_word(1'b1, 1'b1, w0(2'b10, 5'b00000));
        idle(5);
        check("st_end_ph", obs_ph - s_ph, 0);
        check("st_end_pd", obs_pd - s_pd, 0);
        check("st_end_tlp_cnt", int'(tlp_cnt), exp_tlp);

        // Saturate the posted data accumulator: 16 x 256 exceeds 4095.
        hold = 1'b1;
        s_ph = obs_ph; s_pd = obs_pd;
        for (int i = 0; i < 15; i++) send_tlp(2'b10, 5'b00000, 0, 2);
        idle(3);
        check("ovf_below", int'(cred_ovf), 0);
        send_tlp(2'b10, 5'b00000, 0, 2);
        idle(3);
        check("ovf_set", int'(cred_ovf), 1);
        exp_tlp += 16;
        hold = 1'b0;
        idle(25);
        check("ovf_pd_total", obs_pd - s_pd, 4095);
        check("ovf_ph_total", obs_ph - s_ph, 16);
        check("ovf_sticky", int'(cred_ovf), 1);

        // Reset mid-BODY with credits pending.
        hold = 1'b1;
        send_tlp(2'b10, 5'b00000, 10, 4);
        drive_word(1'b1, 1'b0, w0(2'b10, 5'b00000));
        drive_word(1'b0, 1'b0, w1(20));
        drive_word(1'b0, 1'b0, 16'($urandom));
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_tlp_cnt", int'(tlp_cnt), 0);
        check("mid_rst_ovf", int'(cred_ovf), 0);
        check("mid_rst_pulses", int'({ph_p, nph_p, pd_p, npd_p, cpl_seen, unk_seen}), 0);
        check("mid_rst_nums", int'({pd_num, npd_num}), 0);
        hold = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(2);
        s_ph = obs_ph; s_pd = obs_pd; s_nph = obs_nph; s_npd = obs_npd;
        send_tlp(2'b10, 5'b00000, 10, 7);
        idle(8);
        exp_tlp = 1;
        check("post_rst_ph", obs_ph - s_ph, 1);
        check("post_rst_pd", obs_pd - s_pd, 3);
        check("post_rst_np", (obs_nph - s_nph) + (obs_npd - s_npd), 0);
        check("post_rst_tlp_cnt", int'(tlp_cnt), exp_tlp);

        // Randomized TLP stream with random credit_hold.
        s_ph = obs_ph; s_nph = obs_nph; s_pd = obs_pd; s_npd = obs_npd;
        s_cpl = obs_cpl; s_unk = obs_unk;
        e_ph = 0; e_nph = 0; e_pd = 0; e_npd = 0; e_cpl = 0; e_unk = 0;
        rand_hold = 1;
        for (int n = 0; n < 60; n++) begin
            logic [1:0] f;
            logic [4:0] t;
            int len, a, b, c, d, e, g;
            f   = 2'($urandom_range(0, 3));
            t   = pool[$urandom_range(0, 11)];
            len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1023));
            model(f, t, len, a, b, c, d, e, g);
            e_ph += a; e_nph += b; e_pd += c; e_npd += d; e_cpl += e; e_unk += g;
            send_tlp(f, t, len, int'($urandom_range(2, 6)));
            exp_tlp++;
            idle(int'($urandom_range(0, 3)));
        end
        rand_hold = 0;
        hold = 1'b0;
        idle(40);
        check("rand_ph", obs_ph - s_ph, e_ph);
        check("rand_nph", obs_nph - s_nph, e_nph);
        check("rand_pd", obs_pd - s_pd, e_pd);
        check("rand_npd", obs_npd - s_npd, e_npd);
        check("rand_cpl", obs_cpl - s_cpl, e_cpl);
        check("rand_unk", obs_unk - s_unk, e_unk);
        check("rand_tlp_cnt", int'(tlp_cnt), exp_tlp);
        check("rand_no_ovf", int'(cred_ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
